weight_buffer: RTL and testbench

Receiving end of the weight-load interface. Requests a kernel's worth of weight words from the upstream weight source by opening a load window (flush/flush_busy), then captures one word per clock while the window is open. It retains the kernel and streams it, any number of times, to the PE array over a valid/ready handshake. Sits between the weight source (or its bench driver) and the PE array weight inputs.

---
 rtl/weight_buffer.sv | 120 ++++++++++++
 tb/tb_weight_buffer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_buffer.sv
`default_nettype none
// ============================================================================
// weight_buffer : opens a DEPTH-cycle load window to capture one kernel, then
//                 replays it to the PE array over valid/ready on demand.
// Revision 1.0
// ============================================================================
module weight_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 9,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load_req,
  output logic                  flush,
  output logic                  flush_busy,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_start,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic                  w_last,
  output logic                  loaded
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_READY = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                  loaded_q, loaded_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      loaded_q <= loaded_d;
    end
  end

  // Kernel storage is deliberately not reset; loaded_q qualifies its contents.
  always_ff @(posedge clk) begin
    if (state_q == S_FILL) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    loaded_d   = loaded_q;
    flush      = 1'b0;
    flush_busy = 1'b0;
    w_valid    = 1'b0;
    w_last     = 1'b0;
    w_data     = '0;
    case (state_q)
      S_IDLE: begin
        if (load_req) begin
          state_d  = S_FILL;
          loaded_d = 1'b0;
        end
      end
      S_FILL: begin
        flush_busy = 1'b1;
        flush      = (wr_ptr_q == '0);
        if (wr_ptr_q == LAST_IDX) begin
          wr_ptr_d = '0;
          loaded_d = 1'b1;
          state_d  = S_READY;
        end else begin
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
      end
      S_READY: begin
        // rd_start has priority; a simultaneous load_req is dropped.
        if (rd_start) begin
          state_d  = S_DRAIN;
          rd_ptr_d = '0;
        end else if (load_req) begin
          state_d  = S_FILL;
          loaded_d = 1'b0;
        end
      end
      S_DRAIN: begin
        w_valid = 1'b1;
        w_data  = mem[rd_ptr_q];
        w_last  = (rd_ptr_q == LAST_IDX);
        if (w_ready) begin
          if (w_last) begin
            rd_ptr_d = '0;
            state_d  = S_READY;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign loaded = loaded_q;

endmodule
`default_nettype wire

// File: tb/tb_weight_buffer.sv
`default_nettype none
// Testbench for weight_buffer: directed sequence with random noise, checked
// against a counter-based behavioural model of the load/replay protocol.
module tb_weight_buffer;

  localparam int DW = 16;
  localparam int D  = 9;

  logic          clk = 1'b0;
  logic          rstn;
  logic          load_req;
  logic          flush;
  logic          flush_busy;
  logic [DW-1:0] data_in;
  logic          rd_start;
  logic [DW-1:0] w_data;
  logic          w_valid;
  logic          w_ready;
  logic          w_last;
  logic          loaded;

  weight_buffer #(.DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .load_req   (load_req),
    .flush      (flush),
    .flush_busy (flush_busy),
    .data_in    (data_in),
    .rd_start   (rd_start),
    .w_data     (w_data),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_last     (w_last),
    .loaded     (loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model: window counter, replay position, kernel image.
  bit            m_filling, m_draining, m_loaded;
  int            m_fill_cnt, m_pos;
  logic [DW-1:0] m_kernel [D];
  logic [DW-1:0] src [D];
  bit            auto_src = 1'b1;

  int            hs_cnt;
  logic [DW-1:0] got [$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_filling  = 1'b0;
    m_draining = 1'b0;
    m_loaded   = 1'b0;
    m_fill_cnt = 0;
    m_pos      = 0;
  endtask

  task automatic model_edge();
    if (m_filling) begin
      m_kernel[m_fill_cnt] = data_in;
      m_fill_cnt++;
      if (m_fill_cnt == D) begin
        m_filling = 1'b0;
        m_loaded  = 1'b1;
      end
    end else if (m_draining) begin
      if (w_ready) begin
        if (m_pos == D-1) m_draining = 1'b0;
        else m_pos++;
      end
    end else if (m_loaded && rd_start) begin
      m_draining = 1'b1;
      m_pos      = 0;
    end else if (load_req) begin
      m_filling  = 1'b1;
      m_fill_cnt = 0;
      m_loaded   = 1'b0;
    end
  endtask

  task automatic check_outputs();
    chk("flush",      {15'd0, flush},      {15'd0, m_filling && m_fill_cnt == 0});
    chk("flush_busy", {15'd0, flush_busy}, {15'd0, m_filling});
    chk("w_valid",    {15'd0, w_valid},    {15'd0, m_draining});
    chk("w_last",     {15'd0, w_last},     {15'd0, m_draining && m_pos == D-1});
    chk("w_data",     w_data,              m_draining ? m_kernel[m_pos] : 16'h0000);
    chk("loaded",     {15'd0, loaded},     {15'd0, m_loaded});
  endtask

  // One clock cycle: source drives, outputs are checked, the edge is taken.
  task automatic step();
    if (auto_src) data_in = m_filling ? src[m_fill_cnt] : 16'hFFFF;
    check_outputs();
    if (w_valid && w_ready) begin
      hs_cnt++;
      got.push_back(w_data);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic async_reset();
    load_req = 1'($urandom);
    rd_start = 1'($urandom);
    w_ready  = 1'($urandom);
    data_in  = DW'($urandom);
    rstn     = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rstn     = 1'b1;
    load_req = 1'b0;
    rd_start = 1'b0;
    w_ready  = 1'b0;
  endtask

  task automatic load_kernel(input bit noise);
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    for (int i = 0; i < D; i++) begin
      if (noise) begin
        load_req = 1'($urandom);
        rd_start = 1'($urandom);
      end
      step();
    end
    load_req = 1'b0;
    rd_start = 1'b0;
  endtask

  task automatic drain(input bit random_ready, input bit noise);
    int budget;
    hs_cnt   = 0;
    got.delete();
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    budget   = 0;
    while (m_draining && budget < 300) begin
      w_ready = random_ready ? 1'($urandom) : 1'b1;
      if (noise) begin
        load_req = 1'($urandom);
        rd_start = 1'($urandom);
      end
      step();
      budget++;
    end
    chk("drain_timeout", {15'd0, m_draining}, 16'd0);
    load_req = 1'b0;
    rd_start = 1'b0;
    w_ready  = 1'b0;
    step();
    chk("hs_count", 16'(hs_cnt), 16'(D));
  endtask

  task automatic check_seq(input string tag, input logic [DW-1:0] base);
    for (int i = 0; i < D; i++) begin
      chk(tag, (i < got.size()) ? got[i] : 16'hDEAD, base + DW'(i));
    end
  endtask

  initial begin
    rstn     = 1'b0;
    load_req = 1'b0;
    rd_start = 1'b0;
    w_ready  = 1'b0;
    data_in  = '0;
    model_reset();
    for (int i = 0; i < D; i++) m_kernel[i] = 'x;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rstn = 1'b1;

    // Idle: nothing happens, rd_start is ignored.
    repeat (3) step();
    rd_start = 1'b1;
    repeat (2) step();
    rd_start = 1'b0;

    // Load 1..9 with 0xFFFF outside the window.
    for (int i = 0; i < D; i++) src[i] = DW'(i + 1);
    load_kernel(1'b0);
    step();

    // Drain twice without stalls.
    drain(1'b0, 1'b0);
    check_seq("drain1", 16'd1);
    drain(1'b0, 1'b0);
    check_seq("drain2", 16'd1);

    // Backpressure with ignored load_req/rd_start noise.
    drain(1'b1, 1'b1);
    check_seq("drain_bp", 16'd1);

    // rd_start and load_req together in READY: drain wins.
    load_req = 1'b1;
    drain(1'b0, 1'b0);
    check_seq("drain_prio", 16'd1);

    // Random kernel loaded under noise, drained with random stalls.
    for (int i = 0; i < D; i++) src[i] = DW'($urandom);
    load_kernel(1'b1);
    drain(1'b1, 1'b0);
    for (int i = 0; i < D; i++) chk("drain_rand", (i < got.size()) ? got[i] : 16'hDEAD, src[i]);

    // Reset in the middle of a drain.
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    w_ready  = 1'b1;
    repeat (3) step();
    async_reset();
    repeat (2) step();

    // Reset after four captured words, then a full reload with 10..18.
    for (int i = 0; i < D; i++) src[i] = DW'(10 + i);
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    repeat (4) step();
    async_reset();
    step();
    load_kernel(1'b0);
    step();
    drain(1'b1, 1'b0);
    check_seq("reload", 16'd10);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
